// File: rtl/error_counter_arb.sv
// Arbitrated up/down error counter: buffers AGC and loop step requests per source
// and applies one step per timing slot under round-robin arbitration.
module error_counter_arb #(
  parameter int unsigned LIMIT    = 384,
  parameter int unsigned PEND_MAX = 3,
  // Count is sized to hold the full -LIMIT..+LIMIT range.
  localparam int unsigned CW      = $clog2(LIMIT + 1) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ec_enable,
  input  logic                 agc_plus,
  input  logic                 agc_minus,
  input  logic                 _pPGH,
  input  logic                 _mPGH,
  input  logic                 slot,
  output logic signed [CW-1:0] count,
  output logic                 at_limit,
  output logic                 pend_ovf,
  output logic                 dac_strobe
);

  localparam int unsigned PW = $clog2(PEND_MAX + 1) + 1;
  localparam logic signed [CW-1:0] LIM_P  = CW'(LIMIT);
  localparam logic signed [CW-1:0] LIM_N  = -LIM_P;
  localparam logic signed [PW:0]   PMAX_P = (PW + 1)'(PEND_MAX);
  localparam logic signed [PW:0]   PMAX_N = -PMAX_P;

  typedef enum logic {SRC_AGC = 1'b0, SRC_LOOP = 1'b1} src_e;

  logic signed [PW-1:0] pend_agc, pend_agc_nx;
  logic signed [PW-1:0] pend_loop, pend_loop_nx;
  logic signed [CW-1:0] count_nx;
  logic                 pend_ovf_nx, dac_strobe_nx;
  src_e                 last_served, last_served_nx;
  logic                 prev_p, prev_m;
  logic signed [1:0]    req_agc, req_loop, step;
  logic                 agc_nz, loop_nz, serve_agc, serve_loop;
  logic                 drop_agc, drop_loop;

  // Direction of one step toward zero for a buffer value.
  function automatic logic signed [1:0] sgn(input logic signed [PW-1:0] v);
    if (v == '0) return 2'sd0;
    return v[PW-1] ? -2'sd1 : 2'sd1;
  endfunction

  // Combine request and serve; on overflow the request is dropped but the serve stands.
  function automatic logic [PW:0] buf_next(input logic signed [PW-1:0] pend,
                                           input logic signed [1:0]    req,
                                           input logic                 serve);
    logic signed [1:0]  sv;
    logic signed [PW:0] pext, rext, sext, sum, alt;
    sv   = serve ? sgn(pend) : 2'sd0;
    pext = {pend[PW-1], pend};
    rext = {{(PW - 1){req[1]}}, req};
    sext = {{(PW - 1){sv[1]}}, sv};
    sum  = pext + rext - sext;
    alt  = pext - sext;
    if (sum > PMAX_P || sum < PMAX_N) return {1'b1, alt[PW-1:0]};
    return {1'b0, sum[PW-1:0]};
  endfunction

  function automatic logic signed [1:0] req_of(input logic up, input logic dn);
    case ({up, dn})
      2'b10:   return 2'sd1;
      2'b01:   return -2'sd1;
      default: return 2'sd0;
    endcase
  endfunction

  always_comb begin
    req_agc  = req_of(agc_plus, agc_minus);
    req_loop = req_of(prev_p & ~_pPGH, prev_m & ~_mPGH);

    agc_nz     = (pend_agc != '0);
    loop_nz    = (pend_loop != '0);
    serve_agc  = slot & agc_nz & (~loop_nz | (last_served == SRC_LOOP));
    serve_loop = slot & loop_nz & ~serve_agc;

    step = serve_agc ? sgn(pend_agc) : (serve_loop ? sgn(pend_loop) : 2'sd0);

    count_nx = count;
    if (step == 2'sd1 && count != LIM_P)       count_nx = count + CW'(1);
    else if (step == -2'sd1 && count != LIM_N) count_nx = count - CW'(1);

    {drop_agc, pend_agc_nx}   = buf_next(pend_agc, req_agc, serve_agc);
    {drop_loop, pend_loop_nx} = buf_next(pend_loop, req_loop, serve_loop);
    pend_ovf_nx = pend_ovf | drop_agc | drop_loop;

    last_served_nx = last_served;
    if (slot && agc_nz && loop_nz) last_served_nx = serve_agc ? SRC_AGC : SRC_LOOP;

    // Disabled: hold everything cleared and hand the first contest to AGC.
    if (!ec_enable) begin
      count_nx       = '0;
      pend_agc_nx    = '0;
      pend_loop_nx   = '0;
      pend_ovf_nx    = 1'b0;
      last_served_nx = SRC_LOOP;
    end

    dac_strobe_nx = (count_nx != count);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      pend_agc    <= '0;
      pend_loop   <= '0;
      pend_ovf    <= 1'b0;
      dac_strobe  <= 1'b0;
      last_served <= SRC_LOOP;
      prev_p      <= 1'b1;
      prev_m      <= 1'b1;
    end else begin
      count       <= count_nx;
      pend_agc    <= pend_agc_nx;
      pend_loop   <= pend_loop_nx;
      pend_ovf    <= pend_ovf_nx;
      dac_strobe  <= dac_strobe_nx;
      last_served <= last_served_nx;
      prev_p      <= _pPGH;
      prev_m      <= _mPGH;
    end
  end

  assign at_limit = (count == LIM_P) | (count == LIM_N);

endmodule

// File: tb/tb_error_counter_arb.sv
// Directed bench for error_counter_arb; expected slot results go through a scoreboard queue.
module tb_error_counter_arb;

  logic              clk = 1'b0;
  logic              rst_n, ec_enable, agc_plus, agc_minus, p_pgh, m_pgh, slot;
  logic signed [9:0] count;
  logic              at_limit, pend_ovf, dac_strobe;

  typedef struct {
    int count;
    bit strobe;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  error_counter_arb dut (
    .clk(clk), .rst_n(rst_n), .ec_enable(ec_enable),
    .agc_plus(agc_plus), .agc_minus(agc_minus),
    ._pPGH(p_pgh), ._mPGH(m_pgh), .slot(slot),
    .count(count), .at_limit(at_limit), .pend_ovf(pend_ovf), .dac_strobe(dac_strobe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one edge and land just after it.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic agc_pulse(input bit up);
    if (up) agc_plus = 1'b1; else agc_minus = 1'b1;
    cycle();
    agc_plus  = 1'b0;
    agc_minus = 1'b0;
  endtask

  task automatic loop_pulse(input bit up);
    if (up) p_pgh = 1'b0; else m_pgh = 1'b0;
    cycle();
    p_pgh = 1'b1;
    m_pgh = 1'b1;
    cycle();
  endtask

  task automatic do_slot(input string tag, input int exp_c, input bit exp_s);
    exp_t e;
    sb.push_back('{exp_c, exp_s});
    slot = 1'b1;
    cycle();
    slot = 1'b0;
    e = sb.pop_front();
    chk({tag, "_count"}, count, e.count);
    chk({tag, "_strobe"}, {31'd0, dac_strobe}, {31'd0, e.strobe});
  endtask

  task automatic disable_one();
    ec_enable = 1'b0;
    cycle();
    ec_enable = 1'b1;
  endtask

  initial begin
    int e;
    rst_n = 1'b0; ec_enable = 1'b1; agc_plus = 1'b0; agc_minus = 1'b0;
    p_pgh = 1'b1; m_pgh = 1'b1; slot = 1'b0;
    repeat (2) cycle();
    chk("rst_count", count, 0);
    chk("rst_at_limit", {31'd0, at_limit}, 0);
    chk("rst_ovf", {31'd0, pend_ovf}, 0);
    chk("rst_strobe", {31'd0, dac_strobe}, 0);
    rst_n = 1'b1;
    cycle();

    // Three AGC steps then three slots.
    repeat (3) agc_pulse(1'b1);
    do_slot("agc1", 1, 1'b1);
    do_slot("agc2", 2, 1'b1);
    do_slot("agc3", 3, 1'b1);
    chk("agc_ovf", {31'd0, pend_ovf}, 0);
    do_slot("agc_empty", 3, 1'b0);

    // Clear from nonzero strobes once.
    disable_one();
    chk("clr1_count", count, 0);
    chk("clr1_strobe", {31'd0, dac_strobe}, 1);

    // Round-robin: AGC +2, LOOP -2.
    repeat (2) agc_pulse(1'b1);
    repeat (2) loop_pulse(1'b0);
    do_slot("rr1", 1, 1'b1);
    do_slot("rr2", 0, 1'b1);
    do_slot("rr3", 1, 1'b1);
    do_slot("rr4", 0, 1'b1);

    // Loop buffer overflow.
    repeat (3) loop_pulse(1'b1);
    chk("ovf_before", {31'd0, pend_ovf}, 0);
    loop_pulse(1'b1);
    chk("ovf_after", {31'd0, pend_ovf}, 1);
    do_slot("lp1", 1, 1'b1);
    do_slot("lp2", 2, 1'b1);
    do_slot("lp3", 3, 1'b1);
    do_slot("lp_empty", 3, 1'b0);
    chk("ovf_sticky", {31'd0, pend_ovf}, 1);
    disable_one();
    chk("clr2_count", count, 0);
    chk("clr2_ovf", {31'd0, pend_ovf}, 0);

    // Ramp to 383 with request and slot every cycle.
    agc_plus = 1'b1;
    slot = 1'b1;
    repeat (383) cycle();
    agc_plus = 1'b0;
    do_slot("ramp", 383, 1'b1);
    chk("ramp_at_limit", {31'd0, at_limit}, 0);
    repeat (2) agc_pulse(1'b1);
    do_slot("lim1", 384, 1'b1);
    chk("lim1_at_limit", {31'd0, at_limit}, 1);
    do_slot("lim2", 384, 1'b0);
    agc_pulse(1'b0);
    do_slot("lim_back", 383, 1'b1);
    chk("back_at_limit", {31'd0, at_limit}, 0);

    // Same-cycle plus and minus cancel.
    agc_plus = 1'b1; agc_minus = 1'b1;
    cycle();
    agc_plus = 1'b0; agc_minus = 1'b0;
    do_slot("cancel", 383, 1'b0);

    disable_one();
    chk("clr3_count", count, 0);

    // Held-low loop pulse is one request.
    p_pgh = 1'b0;
    repeat (10) cycle();
    p_pgh = 1'b1;
    cycle();
    do_slot("held1", 1, 1'b1);
    do_slot("held2", 1, 1'b0);

    // Walk down to -5.
    e = 1;
    for (int k = 0; k < 2; k++) begin
      repeat (3) agc_pulse(1'b0);
      for (int j = 0; j < 3; j++) begin
        e--;
        do_slot("down", e, 1'b1);
      end
    end
    chk("neg5", count, -5);

    // Pending steps plus overflow, then a one-cycle disable.
    repeat (4) loop_pulse(1'b1);
    repeat (2) agc_pulse(1'b0);
    chk("pre_clr_ovf", {31'd0, pend_ovf}, 1);
    disable_one();
    chk("clr4_count", count, 0);
    chk("clr4_strobe", {31'd0, dac_strobe}, 1);
    chk("clr4_ovf", {31'd0, pend_ovf}, 0);
    cycle();
    chk("clr4_strobe_once", {31'd0, dac_strobe}, 0);
    do_slot("clr4_empty1", 0, 1'b0);
    do_slot("clr4_empty2", 0, 1'b0);

    // Mid-operation reset discards pending steps without a strobe.
    repeat (3) agc_pulse(1'b1);
    do_slot("pre_rst", 1, 1'b1);
    #2 rst_n = 1'b0;
    #2 chk("mid_rst_count", count, 0);
    cycle();
    rst_n = 1'b1;
    cycle();
    chk("rel_strobe", {31'd0, dac_strobe}, 0);
    do_slot("post_rst", 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
